// File: rtl/sa_ctrl_pkg.sv
// Shared definitions for the systolic-array control blocks: FSM state
// encoding and the width of layer configuration fields.
package sa_ctrl_pkg;

  localparam int CFG_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  function automatic logic [CFG_W:0] zext_cfg(input logic [CFG_W-1:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/weight_fetch_ctrl_wrap_counter.sv
// Up-counter that returns to zero after reaching a programmable terminal
// value; o_wrap flags the terminal count so callers can chain counters.
module wrap_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  logic [W-1:0] r_count;

  assign o_wrap  = (r_count == i_term);
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_wrap ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Weight ROM address/enable sequencer: streams kernel elements per fold,
// repeats each fold once per input tile, then steps to the next fold.
module weight_fetch_ctrl
  import sa_ctrl_pkg::*;
#(
  parameter int COLS        = 8,
  parameter int ABS_ADDR_DW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CFG_W-1:0]       KERNEL_NUM,
  input  logic [CFG_W-1:0]       KERNEL_ELEMENT,
  input  logic [CFG_W-1:0]       TILE_NUM,
  input  logic                   ready,
  output logic [CFG_W-1:0]       addr_r,
  output logic [ABS_ADDR_DW-1:0] base_addr,
  output logic [CFG_W-1:0]       rom_select,
  output logic                   data_out_valid,
  output logic                   weight_valid,
  output logic                   fold_last,
  output logic                   busy,
  output logic                   done
);

  state_e                 r_state;
  logic [CFG_W-1:0]       r_kn;
  logic [CFG_W-1:0]       r_ke;
  logic [CFG_W-1:0]       r_tn;
  logic [ABS_ADDR_DW-1:0] r_base;
  logic [CFG_W-1:0]       r_sel;
  logic                   r_wvalid;
  logic                   r_done;
  logic                   r_busy;

  logic                   w_stream;
  logic                   w_beat;
  logic                   w_clr;
  logic                   w_elem_wrap;
  logic                   w_tile_wrap;
  logic [CFG_W-1:0]       w_tile_cnt;
  logic                   w_last_fold;
  logic                   w_fold_end;
  logic                   w_zero_cfg;

  assign w_stream    = (r_state == ST_STREAM);
  assign w_beat      = w_stream && ready;
  assign w_clr       = !w_stream;
  assign w_fold_end  = w_beat && w_elem_wrap && w_tile_wrap;
  assign w_zero_cfg  = (KERNEL_NUM == '0) || (KERNEL_ELEMENT == '0) || (TILE_NUM == '0);

  // 17-bit compare so a rom_select near 2^16 cannot wrap past KERNEL_NUM
  assign w_last_fold = (zext_cfg(r_sel) + (CFG_W+1)'(COLS)) >= zext_cfg(r_kn);

  wrap_counter #(.W(CFG_W)) u_elem_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_en    (w_beat),
    .i_term  (r_ke - 1'b1),
    .o_count (addr_r),
    .o_wrap  (w_elem_wrap)
  );

  wrap_counter #(.W(CFG_W)) u_tile_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_en    (w_beat && w_elem_wrap),
    .i_term  (r_tn - 1'b1),
    .o_count (w_tile_cnt),
    .o_wrap  (w_tile_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_kn     <= '0;
      r_ke     <= '0;
      r_tn     <= '0;
      r_base   <= '0;
      r_sel    <= '0;
      r_wvalid <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_wvalid <= w_beat;
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_kn   <= KERNEL_NUM;
            r_ke   <= KERNEL_ELEMENT;
            r_tn   <= TILE_NUM;
            r_base <= '0;
            r_sel  <= '0;
            if (w_zero_cfg) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_STREAM;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (w_fold_end) begin
            if (w_last_fold) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_base  <= '0;
              r_sel   <= '0;
            end else begin
              r_base <= r_base + ABS_ADDR_DW'(r_ke);
              r_sel  <= r_sel + CFG_W'(COLS);
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_base  <= '0;
          r_sel   <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign base_addr      = r_base;
  assign rom_select     = r_sel;
  assign data_out_valid = w_beat;
  assign weight_valid   = r_wvalid;
  assign fold_last      = w_stream && w_last_fold;
  assign busy           = r_busy;
  assign done           = r_done;

  logic w_unused;
  assign w_unused = ^w_tile_cnt;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Scoreboard bench for weight_fetch_ctrl: expected beats are queued when a
// layer is started and popped as the DUT raises data_out_valid.
module tb_weight_fetch_ctrl;

  typedef struct {
    logic [15:0] base;
    logic [15:0] sel;
    logic [15:0] addr;
    logic        fl;
  } beat_t;

  beat_t sb[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] kn = '0;
  logic [15:0] ke = '0;
  logic [15:0] tn = '0;
  bit          use_w = 1'b0;

  int total_cnt = 0;
  int bad_cnt = 0;

  logic [15:0] a_addr, a_base, a_sel;
  logic        a_dov, a_wv, a_fl, a_busy, a_done;
  logic [15:0] w_addr, w_sel;
  logic [3:0]  w_base;
  logic        w_dov, w_wv, w_fl, w_busy, w_done;

  logic [15:0] o_addr, o_base, o_sel;
  logic        o_dov, o_wv, o_fl, o_busy, o_done;

  always #5 clk = ~clk;

  weight_fetch_ctrl #(.COLS(4), .ABS_ADDR_DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .KERNEL_NUM(kn), .KERNEL_ELEMENT(ke), .TILE_NUM(tn), .ready(ready),
    .addr_r(a_addr), .base_addr(a_base), .rom_select(a_sel),
    .data_out_valid(a_dov), .weight_valid(a_wv), .fold_last(a_fl),
    .busy(a_busy), .done(a_done)
  );

  weight_fetch_ctrl #(.COLS(4), .ABS_ADDR_DW(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start),
    .KERNEL_NUM(kn), .KERNEL_ELEMENT(ke), .TILE_NUM(tn), .ready(ready),
    .addr_r(w_addr), .base_addr(w_base), .rom_select(w_sel),
    .data_out_valid(w_dov), .weight_valid(w_wv), .fold_last(w_fl),
    .busy(w_busy), .done(w_done)
  );

  assign o_addr = use_w ? w_addr : a_addr;
  assign o_base = use_w ? {12'd0, w_base} : a_base;
  assign o_sel  = use_w ? w_sel : a_sel;
  assign o_dov  = use_w ? w_dov : a_dov;
  assign o_wv   = use_w ? w_wv : a_wv;
  assign o_fl   = use_w ? w_fl : a_fl;
  assign o_busy = use_w ? w_busy : a_busy;
  assign o_done = use_w ? w_done : a_done;

  task automatic test_reset();
    use_w = 1'b0;
    rst_n = 1'b0;
    ready = 1'b1;
    #12;
    total_cnt++;
    if ({o_busy, o_done, o_dov, o_wv, o_fl} !== 5'b0) begin
      bad_cnt++;
      $display("[TB] FAIL reset_flags: got %b want 00000", {o_busy, o_done, o_dov, o_wv, o_fl});
    end
    total_cnt++;
    if ({o_addr, o_base, o_sel} !== 48'd0) begin
      bad_cnt++;
      $display("[TB] FAIL reset_regs: got addr=%0d base=%0d sel=%0d want 0", o_addr, o_base, o_sel);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_stream(input int k_num, input int k_el, input int t_num,
                            input int stall_a, input int stall_b, input int repulse_cyc,
                            input bit wide, input string nm);
    int folds, nbeats, nb, stalls, limit, amod;
    bit prev_beat, beat, st_a, st_b, finished;
    beat_t e, g;
    use_w = wide;
    amod = wide ? 16 : 65536;
    folds = (k_num + 3) / 4;
    nbeats = (k_num == 0 || k_el == 0 || t_num == 0) ? 0 : folds * t_num * k_el;
    sb.delete();
    if (nbeats > 0) begin
      for (int f = 0; f < folds; f++)
        for (int t = 0; t < t_num; t++)
          for (int el = 0; el < k_el; el++) begin
            e.base = 16'((f * k_el) % amod);
            e.sel  = 16'(f * 4);
            e.addr = 16'(el);
            e.fl   = (f == folds - 1);
            sb.push_back(e);
          end
    end
    stalls = 0;
    if (stall_a >= 0 && stall_a < nbeats) stalls++;
    if (stall_b >= 0 && stall_b < nbeats && stall_b != stall_a) stalls++;

    kn = 16'(k_num); ke = 16'(k_el); tn = 16'(t_num);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nb = 0; prev_beat = 1'b0; finished = 1'b0; st_a = 1'b0; st_b = 1'b0;
    limit = nbeats + stalls + 5;
    for (int cyc = 1; cyc <= limit && !finished; cyc++) begin
      if (nb < nbeats && nb == stall_a && !st_a) begin
        ready = 1'b0; st_a = 1'b1;
      end else if (nb < nbeats && nb == stall_b && !st_b) begin
        ready = 1'b0; st_b = 1'b1;
      end else begin
        ready = 1'b1;
      end
      if (cyc == repulse_cyc) begin
        start = 1'b1; kn = 16'd1; ke = 16'd1; tn = 16'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (nb < nbeats) begin
        total_cnt++;
        if (o_busy !== 1'b1 || o_done !== 1'b0 || o_dov !== ready) begin
          bad_cnt++;
          $display("[TB] FAIL %s_stream_ctl cyc%0d: got busy=%b done=%b dov=%b want 1 0 %b",
                   nm, cyc, o_busy, o_done, o_dov, ready);
        end
        if (o_dov === 1'b1) begin
          total_cnt++;
          if (sb.size() == 0) begin
            bad_cnt++;
            $display("[TB] FAIL %s_extra_beat cyc%0d: got beat want none", nm, cyc);
          end else begin
            g = sb.pop_front();
            if (o_base !== g.base || o_sel !== g.sel || o_addr !== g.addr || o_fl !== g.fl) begin
              bad_cnt++;
              $display("[TB] FAIL %s_beat%0d: got base=%0d sel=%0d addr=%0d fl=%b want base=%0d sel=%0d addr=%0d fl=%b",
                       nm, nb, o_base, o_sel, o_addr, o_fl, g.base, g.sel, g.addr, g.fl);
            end
          end
        end else begin
          total_cnt++;
          if (nb < nbeats && (o_addr !== sb[0].addr || o_base !== sb[0].base)) begin
            bad_cnt++;
            $display("[TB] FAIL %s_stall_hold cyc%0d: got addr=%0d base=%0d want addr=%0d base=%0d",
                     nm, cyc, o_addr, o_base, sb[0].addr, sb[0].base);
          end
        end
      end else begin
        total_cnt++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_dov !== 1'b0) begin
          bad_cnt++;
          $display("[TB] FAIL %s_done cyc%0d: got done=%b busy=%b dov=%b want 1 0 0",
                   nm, cyc, o_done, o_busy, o_dov);
        end
        finished = 1'b1;
      end
      total_cnt++;
      if (o_wv !== prev_beat) begin
        bad_cnt++;
        $display("[TB] FAIL %s_weight_valid cyc%0d: got %b want %b", nm, cyc, o_wv, prev_beat);
      end
      beat = (nb < nbeats) && ready;
      prev_beat = beat;
      if (beat) nb++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (!finished) begin
      total_cnt++;
      bad_cnt++;
      $display("[TB] FAIL %s_timeout: got no done within %0d cycles want done", nm, limit);
    end
    @(negedge clk);
    total_cnt++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      bad_cnt++;
      $display("[TB] FAIL %s_idle_after: got done=%b busy=%b want 0 0", nm, o_done, o_busy);
    end
    total_cnt++;
    if (sb.size() != 0) begin
      bad_cnt++;
      $display("[TB] FAIL %s_leftover: got %0d beats unissued want 0", nm, sb.size());
    end
  endtask

  task automatic test_basic();
    run_stream(6, 3, 2, -1, -1, -1, 1'b0, "basic");
  endtask

  task automatic test_stall();
    run_stream(6, 3, 2, 1, 6, -1, 1'b0, "stall");
  endtask

  task automatic test_exact_fold();
    run_stream(8, 3, 1, -1, -1, -1, 1'b0, "exact");
  endtask

  task automatic test_zero_cfg();
    run_stream(6, 3, 0, -1, -1, -1, 1'b0, "zero_tile");
    run_stream(0, 3, 2, -1, -1, -1, 1'b0, "zero_kn");
  endtask

  task automatic test_restart_ignored();
    run_stream(6, 3, 2, -1, -1, 3, 1'b0, "repulse");
  endtask

  task automatic test_addr_wrap();
    run_stream(12, 9, 1, -1, -1, -1, 1'b1, "wrap");
  endtask

  task automatic test_mid_reset();
    use_w = 1'b0;
    kn = 16'd6; ke = 16'd3; tn = 16'd2;
    ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({o_busy, o_done, o_dov, o_wv, o_fl} !== 5'b0) begin
      bad_cnt++;
      $display("[TB] FAIL midreset_flags: got %b want 00000", {o_busy, o_done, o_dov, o_wv, o_fl});
    end
    total_cnt++;
    if ({o_addr, o_base, o_sel} !== 48'd0) begin
      bad_cnt++;
      $display("[TB] FAIL midreset_regs: got addr=%0d base=%0d sel=%0d want 0", o_addr, o_base, o_sel);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_stream(6, 3, 2, -1, -1, -1, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_exact_fold();
    test_zero_cfg();
    test_restart_ignored();
    test_addr_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/weight_fetch_ctrl.md
# weight_fetch_ctrl

Address and enable sequencer that drives the weight ROM bank (`weight_rom` / `weight_rom2`) directly upstream of it. For each column fold of `COLS` kernels it streams `addr_r` over the kernel elements, repeats the fold `TILE_NUM` times (once per input tile), then advances `base_addr` and `rom_select` to the next fold. It sits between the layer controller (`start`/`done`) and the systolic array's weight-ready backpressure.

## Interface
- `COLS`, 8, array columns = kernels per fold = `rom_select` step
- `ABS_ADDR_DW`, 16, width of `base_addr`
- `clk` in 1, sole clock, rising edge
- `rst_n` in 1, asynchronous active-low reset
- `start` in 1, single-cycle layer start pulse; ignored while `busy`
- `KERNEL_NUM` in 16, total kernels in layer, sampled at `start`
- `KERNEL_ELEMENT` in 16, elements per kernel, sampled at `start`
- `TILE_NUM` in 16, repeats of each fold, sampled at `start`
- `ready` in 1, array can accept one weight beat this cycle
- `addr_r` out 16, element index within kernel
- `base_addr` out ABS_ADDR_DW, fold offset = fold × KERNEL_ELEMENT
- `rom_select` out 16, first kernel of current fold = fold × COLS
- `data_out_valid` out 1, ROM read enable for this beat
- `weight_valid` out 1, `data_out_valid` delayed one cycle; qualifies ROM `data_out`
- `fold_last` out 1, current beat belongs to the last fold
- `busy` out 1, STREAM state
- `done` out 1, one-cycle pulse after final beat

## Operation
- States: IDLE, STREAM, DONE.
- IDLE: on `start`, latch config; if any of KERNEL_NUM, KERNEL_ELEMENT, TILE_NUM is 0 go to DONE, else STREAM with `addr_r`=0, tile=0, `base_addr`=0, `rom_select`=0.
- STREAM: `data_out_valid` = `ready` (combinational). A beat occurs when `ready`=1; on a beat:
  - `addr_r` < KERNEL_ELEMENT−1: `addr_r`+1.
  - else `addr_r`←0; if tile < TILE_NUM−1: tile+1 (same fold, same base/select).
  - else tile←0; if `rom_select`+COLS ≥ KERNEL_NUM (computed at 17 bits): go DONE; else `base_addr`+=KERNEL_ELEMENT (wraps mod 2^ABS_ADDR_DW), `rom_select`+=COLS.
- No beat when `ready`=0: all counters hold; address stays on the un-issued element.
- DONE: `done`=1 for one cycle, counters cleared, → IDLE. `start` in DONE is ignored.
- Folds = ceil(KERNEL_NUM/COLS); total beats = folds × TILE_NUM × KERNEL_ELEMENT. Partial last fold is still streamed in full; lane masking is done downstream by `rom_select`.
- `fold_last` = STREAM && `rom_select`+COLS ≥ KERNEL_NUM.

## Timing
- Reset (async, any state): state IDLE; `addr_r`, `base_addr`, `rom_select`, tile, `weight_valid`, `done`, `busy` = 0; `data_out_valid` = 0.
- `start` sampled at edge 0 → `busy`=1 from cycle 1; first beat possible in cycle 1.
- `addr_r`/`base_addr`/`rom_select` registered; stable the whole cycle `data_out_valid` is high.
- `weight_valid` registered: high in cycle n+1 iff a beat occurred in cycle n (matches 1-cycle ROM latency and `rd_en_r`).
- Final beat at cycle n → `busy`=0, `done`=1 at n+1; IDLE at n+2; new `start` accepted at n+2.
- Zero config: `start` at edge 0 → `done`=1 in cycle 1, no beats.

## Structure
- Shared package `sa_ctrl_pkg`: state encoding (IDLE/STREAM/DONE), config field width 16.
- One sub-module natural: `wrap_counter` (enable, terminal value, wrap flag), instanced for element and tile counters.

## Test plan
- COLS=4, KERNEL_NUM=6, KERNEL_ELEMENT=3, TILE_NUM=2, `ready`=1 → 12 beats: (base,sel,addr) = (0,0,0..2)×2 then (3,4,0..2)×2; `fold_last` on last 6; `done` in cycle 13.
- Same config, `ready` low on beats 2 and 7 → addresses hold during stalls, same 12-beat sequence, `done` delayed 2 cycles; `weight_valid` gaps track the stalls one cycle later.
- KERNEL_NUM=8, COLS=4 (exact multiple) → 2 folds, `rom_select` 0,4, never 8.
- TILE_NUM=0 → `done` in cycle 1, `data_out_valid` never high.
- `start` re-pulsed mid-STREAM → ignored, sequence unchanged; `rst_n` low mid-STREAM → all outputs 0 immediately, IDLE, next `start` restarts at 0.
- ABS_ADDR_DW=4, KERNEL_ELEMENT=9, KERNEL_NUM=12, COLS=4 → `base_addr` 0, 9, 2 (wrapped).
